// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: PC register plus IDLE/FETCH/WAIT/HALT control of imem requests.
// imem_req/fetch_valid are combinational from state and inputs; PC and state update on the next rising clk.
module fetch_sequencer #(
  parameter logic [7:0] RESET_VECTOR = 8'h00,
  parameter logic [7:0] PC_STEP      = 8'd1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall,
  input  logic       branch_taken,
  input  logic [7:0] branch_target,
  input  logic       jump,
  input  logic [7:0] jump_target,
  input  logic       halt,
  input  logic       resume,
  input  logic       imem_ack,
  output logic       imem_req,
  output logic [7:0] imem_addr,
  output logic [7:0] pc_out,
  output logic       fetch_valid,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_pc;
  logic [7:0] w_pc_nxt;
  logic       w_req;
  logic       w_redirect;
  logic [7:0] w_redirect_pc;

  // Jump outranks a same-cycle taken branch.
  assign w_redirect    = jump | branch_taken;
  assign w_redirect_pc = jump ? jump_target : branch_target;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_req       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_FETCH;
      end
      S_FETCH, S_WAIT: begin
        if (w_redirect) begin
          w_pc_nxt    = w_redirect_pc;
          w_state_nxt = S_FETCH;
        end else if (halt) begin
          w_state_nxt = S_HALT;
        end else if (!stall) begin
          w_req = 1'b1;
          if (imem_ack) begin
            w_pc_nxt    = r_pc + PC_STEP;
            w_state_nxt = S_FETCH;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_HALT: begin
        if (w_redirect) begin
          w_pc_nxt = w_redirect_pc;
        end
        // A halt request still present wins over resume.
        if (resume && !halt) begin
          w_state_nxt = S_FETCH;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_VECTOR;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  assign imem_req    = w_req & ~rst;
  assign fetch_valid = imem_req & imem_ack;
  assign imem_addr   = r_pc;
  assign pc_out      = r_pc;
  assign state       = r_state;

endmodule
